// File: rtl/aes_pkg.sv
// Shared AES round definitions: widths, the GF(2^8) reduction constant,
// xtime, and the round-block FSM states.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int BYTE_W      = 8;
    localparam logic [BYTE_W-1:0] GF_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Multiply by x in GF(2^8), reduced by x^8 + x^4 + x^3 + x + 1.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns of one 32-bit column; byte 0 (row 0) sits in bits [31:24].
module mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [BYTE_W-1:0] a [4];
    logic [BYTE_W-1:0] a2 [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
            assign a[gi]  = col_in[31-8*gi -: 8];
            assign a2[gi] = xtime(a[gi]);
        end
    endgenerate

    // 3*x is written as xtime(x) ^ x.
    assign col_out[31:24] = a2[0] ^ (a2[1] ^ a[1]) ^ a[2] ^ a[3];
    assign col_out[23:16] = a[0] ^ a2[1] ^ (a2[2] ^ a[2]) ^ a[3];
    assign col_out[15:8]  = a[0] ^ a[1] ^ a2[2] ^ (a2[3] ^ a[3]);
    assign col_out[7:0]   = (a2[0] ^ a[0]) ^ a[1] ^ a[2] ^ a2[3];

endmodule

// File: rtl/shift_mix_columns.sv
// AES ShiftRows + MixColumns round stage: captures a state, mixes one column
// per cycle through a single shared column unit, then holds the result.
module shift_mix_columns
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [AES_STATE_W-1:0] message,
    input  logic                   in_valid,
    input  logic                   final_round,
    output logic                   in_ready,
    output logic [AES_STATE_W-1:0] Emessage,
    output logic                   out_valid,
    input  logic                   out_ready
);

    state_t                 state_reg, state_next;
    logic [1:0]             col_reg;
    logic [AES_STATE_W-1:0] shifted_reg;
    logic                   final_reg;
    logic [AES_STATE_W-1:0] emessage_reg;

    logic [AES_STATE_W-1:0] shifted;
    logic [31:0]            cols [4];
    logic [31:0]            cur_col;
    logic [31:0]            mixed_col;
    logic [31:0]            col_result;
    logic                   accept;

    // Byte (r,c) of the output takes byte (r,(c+r)%4) of the input.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_shift
            localparam int R = gi % 4;
            localparam int C = gi / 4;
            localparam int SRC = 4 * ((C + R) % 4) + R;
            assign shifted[127-8*gi -: 8] = message[127-8*SRC -: 8];
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_cols
            assign cols[gi] = shifted_reg[127-32*gi -: 32];
        end
    endgenerate

    assign cur_col = cols[col_reg];

    mix_single_column u_mix (
        .col_in  (cur_col),
        .col_out (mixed_col)
    );

    assign col_result = final_reg ? cur_col : mixed_col;
    assign accept     = (state_reg == IDLE) && in_valid;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)      state_next = BUSY;
            BUSY:    if (col_reg == 2'd3) state_next = DONE;
            DONE:    if (out_ready)     state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg      <= 2'd0;
            shifted_reg  <= '0;
            final_reg    <= 1'b0;
            emessage_reg <= '0;
        end else if (accept) begin
            shifted_reg <= shifted;
            final_reg   <= final_round;
            col_reg     <= 2'd0;
        end else if (state_reg == BUSY) begin
            case (col_reg)
                2'd0:    emessage_reg[127:96] <= col_result;
                2'd1:    emessage_reg[95:64]  <= col_result;
                2'd2:    emessage_reg[63:32]  <= col_result;
                default: emessage_reg[31:0]   <= col_result;
            endcase
            col_reg <= col_reg + 2'd1;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign Emessage  = emessage_reg;

endmodule

// File: tb/tb_shift_mix_columns.sv
// Bench for shift_mix_columns: directed FIPS-197 vectors, backpressure, reset
// abort, back-to-back and random blocks against a byte-level AES model.
module tb_shift_mix_columns;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] message;
    logic         in_valid;
    logic         final_round;
    logic         in_ready;
    logic [127:0] Emessage;
    logic         out_valid;
    logic         out_ready;

    int passes = 0;
    int fails  = 0;
    int checks = 0;
    int cyc    = 0;

    shift_mix_columns dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .message     (message),
        .in_valid    (in_valid),
        .final_round (final_round),
        .in_ready    (in_ready),
        .Emessage    (Emessage),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // Reference round: state as a 4x4 byte grid, rows rotated, then the
    // circulant {2,3,1,1} matrix applied column by column.
    function automatic logic [127:0] ref_model(input logic [127:0] m, input logic fr);
        logic [7:0]   st [4][4];
        logic [7:0]   sr [4][4];
        logic [7:0]   acc;
        logic [127:0] res = '0;
        int           base [4] = '{2, 3, 1, 1};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = m[127-8*(4*c+r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[r][c] = st[r][(c+r)%4];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                if (fr) acc = sr[r][c];
                else begin
                    acc = 8'h00;
                    for (int k = 0; k < 4; k++)
                        acc = acc ^ gmul(8'(base[(k-r+4)%4]), sr[k][c]);
                end
                res[127-8*(4*c+r) -: 8] = acc;
            end
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_block(input string name, input logic [127:0] msg, input logic fr,
                             input logic [127:0] exp, input int hold, output int acc_cyc);
        int n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        chk({name, "_in_ready"}, in_ready, 1'b1);
        message = msg; final_round = fr; in_valid = 1'b1;
        out_ready = (hold == 0);
        step();
        acc_cyc = cyc;
        in_valid = 1'b0; message = rnd128(); final_round = ~fr;
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        chk({name, "_latency"}, 128'(n), 128'd4);
        chk({name, "_emessage"}, Emessage, exp);
        chk({name, "_busy_in_ready"}, in_ready, 1'b0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; message = rnd128(); final_round = $urandom_range(0, 1) == 1;
            step();
            chk({name, "_hold_valid"}, out_valid, 1'b1);
            chk({name, "_hold_data"}, Emessage, exp);
            chk({name, "_hold_in_ready"}, in_ready, 1'b0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk({name, "_idle_in_ready"}, in_ready, 1'b1);
        chk({name, "_idle_out_valid"}, out_valid, 1'b0);
        $display("block %s fr=%0b msg=%h result=%h", name, fr, msg, Emessage);
    endtask

    localparam logic [127:0] VEC     = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] VEC_MIX = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] VEC_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] COL_IN  = {4{32'hdb135345}};
    localparam logic [127:0] COL_OUT = {4{32'h8e4da1bc}};

    initial begin
        int a0, a1;
        logic [127:0] m;
        logic         f;
        logic         seen;

        rst_n = 1'b0; message = '0; in_valid = 1'b0; final_round = 1'b0; out_ready = 1'b1;
        #12;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_emessage", Emessage, 128'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Model sanity against the published vectors, then the DUT.
        chk("model_vec", ref_model(VEC, 1'b0), VEC_MIX);
        chk("model_col", ref_model(COL_IN, 1'b0), COL_OUT);
        run_block("fips_mix", VEC, 1'b0, VEC_MIX, 0, a0);
        run_block("fips_final", VEC, 1'b1, VEC_SR, 0, a0);
        run_block("column", COL_IN, 1'b0, COL_OUT, 0, a0);
        run_block("backpressure", VEC, 1'b0, VEC_MIX, 10, a0);

        // Reset abort with col at 2.
        message = rnd128(); final_round = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_emessage", Emessage, 128'h0);
        step(); step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_out_valid", seen, 1'b0);
        $display("block abort reset released, out_valid seen=%0b", seen);
        run_block("after_abort", VEC, 1'b0, VEC_MIX, 0, a0);

        // Back-to-back throughput.
        m = rnd128();
        run_block("b2b_first", VEC, 1'b0, VEC_MIX, 0, a0);
        run_block("b2b_second", m, 1'b0, ref_model(m, 1'b0), 0, a1);
        chk("b2b_spacing", 128'(a1 - a0), 128'd6);

        for (int i = 0; i < 8; i++) begin
            m = rnd128();
            f = $urandom_range(0, 1) == 1;
            run_block("random", m, f, ref_model(m, f), (i == 3) ? 3 : 0, a0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/shift_mix_columns.md
SHIFT_MIX_COLUMNS -- requirements
Module: shift_mix_columns

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-003 SHALL have port message, input, 128, SubBytes output state, column-major: [127:120]=s(0,0), [119:112]=s(1,0), ..., [7:0]=s(3,3).
REQ-004 SHALL have port in_valid, input, 1, message valid.
REQ-005 SHALL have port final_round, input, 1, sampled with message; 1 = ShiftRows only, no MixColumns.
REQ-006 SHALL have port in_ready, output, 1, block can accept message.
REQ-007 SHALL have port Emessage, output, 128, ShiftRows+MixColumns result, same byte ordering as message.
REQ-008 SHALL have port out_valid, output, 1, Emessage valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts Emessage.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-011 SHALL assert in_ready only in IDLE; SHALL deassert out_valid outside DONE.
REQ-012 SHALL treat an accept as rising edge with in_valid=1 and in_ready=1: register ShiftRows(message) and final_round, clear col counter, go BUSY.
REQ-013 SHALL perform ShiftRows as a cyclic left shift of row r by r bytes (r=0..3).
REQ-014 SHALL process one column per cycle in BUSY, col = 0,1,2,3, with a 2-bit counter; after col 3, go DONE.
REQ-015 SHALL compute MixColumns per column over GF(2^8), polynomial 0x11B, matrix rows {02 03 01 01}, {01 02 03 01}, {01 01 02 03}, {03 01 01 02}; xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0).
REQ-016 SHALL pass the shifted column through unchanged when final_round=1; timing SHALL be identical, 4 BUSY cycles.
REQ-017 SHALL assert out_valid on the 4th rising edge after the accept edge (fixed latency 4); Emessage SHALL be stable while out_valid=1.
REQ-018 SHALL hold out_valid and Emessage in DONE until an edge with out_ready=1, then go IDLE; in_ready SHALL rise the cycle after.
REQ-019 SHALL ignore in_valid in BUSY and DONE; message and final_round changes there SHALL NOT affect the result.
REQ-020 SHALL give a throughput of one block per 6 cycles with out_ready tied high.

Reset
REQ-021 SHALL on rst_n=0, immediately and regardless of clk, set state=IDLE, col=0, Emessage=128'h0, out_valid=0, in_ready=1; final_round register=0.
REQ-022 SHALL abort an in-flight block on reset mid-BUSY/DONE; no out_valid for it after release.
REQ-023 SHALL allow the first accept on the first rising edge with rst_n=1.

Structure
REQ-024 SHALL place in shared package aes_pkg: AES_STATE_W=128, BYTE_W=8, GF poly constant 8'h1B, xtime function, FSM state enum.
REQ-025 SHALL implement one combinational sub-module mix_single_column (32-bit column in, 32-bit out); instantiated once, muxed by col.

Verification
REQ-026 SHALL cover FIPS-197 App. B round 1: message=128'hd42711aee0bf98f1b8b45de51e415230, final_round=0 -> Emessage=128'h046681e5e0cb199a48f8d37a2806264c, out_valid exactly 4 edges after accept.
REQ-027 SHALL cover the same message with final_round=1 -> Emessage=128'hd4bf5d30e0b452aeb84111f11e2798e5.
REQ-028 SHALL cover the single column check: all four columns = 32'hdb135345, final_round=0 (ShiftRows invariant) -> every column 32'h8e4da1bc.
REQ-029 SHALL cover backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and Emessage held, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-030 SHALL cover reset abort: rst_n pulsed low at col=2 -> outputs at reset values asynchronously, no out_valid after release, next block (REQ-026 vector) correct.
REQ-031 SHALL cover back-to-back: two blocks with out_ready=1 -> second accepted 6 cycles after first, both results correct.
